vga_pixel_sink: RTL
===================

VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter BG_COLOUR, default 12'h884, colour loaded by the clear engine.
REQ-003 Parameter H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixel periods.
REQ-004 Parameter V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-005 Ports:
- CLOCK_50  in  1   50 MHz system clock.
- reset  in  1   synchronous active-high reset.
- x  in  9   write column, 0..319.
- y  in  8   write row, 0..239.
- colour  in  12  [11:8] R, [7:4] G, [3:0] B.
- plot  in  1   write strobe, sampled every CLOCK_50 edge.
- frame_start  out  1   one-cycle pulse at start of vertical front porch.
- clear_busy  out  1   clear engine active.
- VGA_CLK  out  1   25 MHz pixel clock.
- VGA_HS, VGA_VS  out  1   syncs, active-low.
- VGA_BLANK_N  out  1   high only during visible pixels.
- VGA_SYNC_N  out  1   constant 0.
- VGA_R, VGA_G, VGA_B  out  8   channel data.

Function
REQ-006 Internal pixel enable pe SHALL toggle every CLOCK_50 cycle; VGA_CLK SHALL equal ~pe, registered.
REQ-007 Frame store SHALL be 76800 x 12-bit RAM, one write port and one read port, 1-cycle read latency.
REQ-008 A plot-high cycle with x<320 and y<240 SHALL write colour to address y*320+x on that edge; out-of-range writes are dropped with no side effect.
REQ-009 Same-address read and write in one cycle SHALL return old data.
REQ-010 Counters hc (0..799) and vc (0..524) SHALL advance on pe cycles only; hc wraps 799->0 and increments vc; vc wraps 524->0.
REQ-011 Read address SHALL be (vc>>1)*320 + (hc>>1), computed with shifts and adds only, no multiplier.
REQ-012 HS SHALL be low for hc in 656..751; VS SHALL be low for vc in 490..491; BLANK_N SHALL be high for hc<640 and vc<480.
REQ-013 HS, VS and BLANK_N SHALL be delayed through the same number of pe stages as the RAM path, so RGB for pixel (hc,vc) coincides with its sync/blank; total latency from counter value to pins SHALL be 2 pixel periods.
REQ-014 Each 8-bit channel SHALL be the 4-bit nibble replicated ({c,c}); when BLANK_N is low, RGB SHALL be 0.
REQ-015 frame_start SHALL pulse high for exactly one CLOCK_50 cycle when vc becomes 480 with hc=0.
REQ-016 Writes SHALL be accepted in every cycle regardless of scan position; no handshake or back-pressure.

Reset
REQ-017 While reset is high: hc=vc=0, pe=0, VGA_CLK=0, HS=VS=1, BLANK_N=0, RGB=0, frame_start=0, delay pipeline flushed to blank.
REQ-018 RAM contents SHALL not be altered by reset except through the clear engine.
REQ-019 Reset asserted mid-frame SHALL restart timing at (0,0) on the first cycle after deassertion; no partial-line sync glitch beyond that restart.

Configuration
REQ-020 Macro VGA_PIXEL_SINK_CLEAR_EN defined: after reset deasserts, clear engine writes BG_COLOUR to addresses 0..76799, one per CLOCK_50 cycle, clear_busy high throughout (76800 cycles); plot writes are ignored while clear_busy; reset during clear restarts it from address 0.
REQ-021 Macro undefined: no clear engine; clear_busy constant 0; RAM power-up content undefined.

Verification
REQ-022 Release reset, run one frame -> HS period 1600 CLOCK_50 cycles, low 192 cycles; VS period 840000 cycles, low 3200 cycles.
REQ-023 plot x=0,y=0,colour=12'hF0A, next frame -> first visible 2x2 block RGB=FF/00/AA coincident with BLANK_N rising, adjacent pixel from its own address.
REQ-024 plot x=320,y=5 and x=3,y=240 -> no RAM location changes; visible output identical to prior frame.
REQ-025 plot x=319,y=239,colour=12'h123 -> last visible pixel pair of lines 478..479 = 11/22/33; RGB=0 at hc=640 output slot.
REQ-026 With VGA_PIXEL_SINK_CLEAR_EN: reset, pulse plot during clear -> clear_busy high 76800 cycles, whole frame BG_COLOUR (88/88/44), plotted pixel absent.
REQ-027 Assert reset at vc=300 for 3 cycles -> outputs hit reset values, frame_start next pulses exactly 768000 cycles after deassertion.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: 320x240x12 frame store, scanned out as 640x480 VGA with each stored pixel doubled in x and y.
// Latency: a plot lands in RAM on the edge it is sampled; pins trail the scan counters by 2 pixel periods.
// Backpressure: none, plot is taken every cycle; VGA_PIXEL_SINK_CLEAR_EN adds a post-reset clear that ignores plot while busy.
module vga_pixel_sink #(
  parameter logic [11:0] BG_COLOUR = 12'h884,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic [11:0] colour,
  input  logic        plot,
  output logic        frame_start,
  output logic        clear_busy,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int RAM_WORDS = 76800;

  localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] V_FS    = 10'(V_VIS - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

  logic        pe;
  logic [9:0]  hc, vc;
  logic [11:0] mem [0:RAM_WORDS-1];
  logic [11:0] rd_dat;
  logic [16:0] rd_addr, plot_addr, wr_addr, clr_addr;
  logic [11:0] wr_dat;
  logic        wr_en, clr_active, in_range;
  logic        vis, hs_raw, vs_raw;
  logic [11:0] pix1;
  logic        hs1, vs1, blank1;

  assign VGA_SYNC_N = 1'b0;

  // Pixel enable, registered pixel clock, scan counters and frame_start pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pe          <= 1'b0;
      VGA_CLK     <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
    end else begin
      pe          <= ~pe;
      VGA_CLK     <= ~pe;
      frame_start <= pe && (hc == H_LAST) && (vc == V_FS);
      if (pe) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  // Raw timing decode and scan read address; x320 built as x256 + x64
  always_comb begin
    vis       = (hc < H_VIS_L) && (vc < V_VIS_L);
    hs_raw    = !((hc >= HS_BEG) && (hc < HS_END));
    vs_raw    = !((vc >= VS_BEG) && (vc < VS_END));
    rd_addr   = '0;
    if (vis)
      rd_addr = {1'b0, vc[8:1], 8'b0} + {3'b0, vc[8:1], 6'b0} + {8'b0, hc[9:1]};
    in_range  = (x < 9'd320) && (y < 8'd240);
    plot_addr = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  end

`ifdef VGA_PIXEL_SINK_CLEAR_EN
  logic clr_busy_q;

  // Clear sweep over the whole store, restarted from address 0 by every reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clr_addr   <= '0;
      clr_busy_q <= 1'b1;
    end else if (clr_busy_q) begin
      clr_addr <= clr_addr + 17'd1;
      if (clr_addr == 17'(RAM_WORDS - 1))
        clr_busy_q <= 1'b0;
    end
  end

  assign clear_busy = clr_busy_q;
  assign clr_active = clr_busy_q;
`else
  assign clear_busy = 1'b0;
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
`endif

  // Write port arbitration: the clear sweep owns the port while busy, plot is dropped
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = plot_addr;
    wr_dat  = colour;
    if (clr_active) begin
      wr_en   = !reset;
      wr_addr = clr_addr;
      wr_dat  = BG_COLOUR;
    end else if (plot && in_range) begin
      wr_en   = 1'b1;
    end
  end

  // Frame store write port
  always_ff @(posedge CLOCK_50) begin
    if (wr_en)
      mem[wr_addr] <= wr_dat;
  end

  // Frame store read port, one cycle latency, old data on address collision
  always_ff @(posedge CLOCK_50) begin
    rd_dat <= mem[rd_addr];
  end

  // Two pe-stage pipeline keeping sync/blank aligned with the RAM data
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pix1        <= '0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      blank1      <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pe) begin
      pix1        <= rd_dat;
      hs1         <= hs_raw;
      vs1         <= vs_raw;
      blank1      <= vis;
      VGA_HS      <= hs1;
      VGA_VS      <= vs1;
      VGA_BLANK_N <= blank1;
      VGA_R       <= blank1 ? {pix1[11:8], pix1[11:8]} : 8'd0;
      VGA_G       <= blank1 ? {pix1[7:4],  pix1[7:4]}  : 8'd0;
      VGA_B       <= blank1 ? {pix1[3:0],  pix1[3:0]}  : 8'd0;
    end
  end

endmodule
